// File: rtl/vga_timing_generator_pkg.sv
// Raster constants, shared types and the coordinate mapping for the 640x480@60 VGA timing generator.
package vga_timing_generator_pkg;

  typedef logic [11:0] cnt_t;

  localparam cnt_t H_VISIBLE = 12'd640;
  localparam cnt_t H_FP      = 12'd16;
  localparam cnt_t H_SYNC    = 12'd96;
  localparam cnt_t H_BP      = 12'd48;
  localparam cnt_t H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam cnt_t V_VISIBLE = 12'd480;
  localparam cnt_t V_FP      = 12'd10;
  localparam cnt_t V_SYNC    = 12'd2;
  localparam cnt_t V_BP      = 12'd33;
  localparam cnt_t V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam cnt_t FRAME_WIDTH  = H_VISIBLE;
  localparam cnt_t FRAME_HEIGHT = V_VISIBLE;

  localparam cnt_t H_SYNC_START = H_VISIBLE + H_FP;
  localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC - 12'd1;
  localparam cnt_t H_LAST       = H_TOTAL - 12'd1;
  localparam cnt_t V_SYNC_START = V_VISIBLE + V_FP;
  localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC - 12'd1;
  localparam cnt_t V_LAST       = V_TOTAL - 12'd1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

  typedef enum logic {
    ST_START,
    ST_RUN
  } run_state_t;

  // 1-based coordinate inside the visible span, 0 outside it.
  function automatic cnt_t map_coord(input cnt_t cnt, input cnt_t visible);
    return (cnt < visible) ? cnt + 12'd1 : 12'd0;
  endfunction

endpackage

// File: rtl/vga_timing_generator_delay_line.sv
// Fixed-depth register chain with a tap one stage short of the end; latency DEPTH, no backpressure.
module vga_delay_line #(
  parameter int               WIDTH       = 3,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLOCK_25,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_dat,
  output logic [WIDTH-1:0] out_dat,
  output logic [WIDTH-1:0] tap_dat
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VALUE;
    end else begin
      stage[0] <= in_dat;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign out_dat = stage[DEPTH-1];

  // The tap is DEPTH-1 stages behind the input; with a single stage that is the input itself.
  generate
    if (DEPTH == 1) begin : g_tap_direct
      assign tap_dat = in_dat;
    end else begin : g_tap_stage
      assign tap_dat = stage[DEPTH-2];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_generator.sv
// 640x480@60 raster counters, 1-based x/y for the image generator and the VGA pins.
// Pins lag x/y by SYNC_DELAY cycles; free-running, no backpressure.
module vga_timing_generator
  import vga_timing_generator_pkg::*;
#(
  parameter int COLOR_DEPTH = 8,
  parameter int SYNC_DELAY  = 1
) (
  input  logic                   CLOCK_25,
  input  logic                   reset_n,
  input  logic [2:0]             color,
  output logic [11:0]            x,
  output logic [11:0]            y,
  output logic                   frame_tick,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK_N,
  output logic                   VGA_SYNC_N,
  output logic [COLOR_DEPTH-1:0] VGA_R,
  output logic [COLOR_DEPTH-1:0] VGA_G,
  output logic [COLOR_DEPTH-1:0] VGA_B
);

  run_state_t state_q, state_d;
  logic       run;
  cnt_t       h_cnt, v_cnt, h_nxt, v_nxt;
  sync_t      raw, dly, tap;

  // The first edge after reset only loads x/y for (0,0); counting starts on the next one.
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) state_q <= ST_START;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      ST_START: state_d = ST_RUN;
      ST_RUN:   run     = 1'b1;
      default:  state_d = ST_START;
    endcase
  end

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (run) begin
      if (h_cnt == H_LAST) begin
        h_nxt = 12'd0;
        v_nxt = (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
      end else begin
        h_nxt = h_cnt + 12'd1;
      end
    end
  end

  // x/y and frame_tick come from next-state values so they line up with h_cnt/v_cnt.
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt      <= 12'd0;
      v_cnt      <= 12'd0;
      x          <= 12'd0;
      y          <= 12'd0;
      frame_tick <= 1'b0;
    end else begin
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      x          <= map_coord(h_nxt, FRAME_WIDTH);
      y          <= map_coord(v_nxt, FRAME_HEIGHT);
      frame_tick <= (h_nxt == 12'd0) && (v_nxt == V_VISIBLE);
    end
  end

  always_comb begin
    raw = SYNC_IDLE;
    if (run) begin
      raw.hs  = !((h_cnt >= H_SYNC_START) && (h_cnt <= H_SYNC_END));
      raw.vs  = !((v_cnt >= V_SYNC_START) && (v_cnt <= V_SYNC_END));
      raw.vis = (h_cnt < FRAME_WIDTH) && (v_cnt < FRAME_HEIGHT);
    end
  end

  vga_delay_line #(
    .WIDTH       ($bits(sync_t)),
    .DEPTH       (SYNC_DELAY),
    .RESET_VALUE (SYNC_IDLE)
  ) u_sync_dly (
    .CLOCK_25 (CLOCK_25),
    .reset_n  (reset_n),
    .in_dat   (raw),
    .out_dat  (dly),
    .tap_dat  (tap)
  );

  // Color arrives SYNC_DELAY-1 cycles after its x/y, so the tap gates it onto the pins in step with BLANK_N.
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end else if (tap.vis) begin
      VGA_R <= {COLOR_DEPTH{color[2]}};
      VGA_G <= {COLOR_DEPTH{color[1]}};
      VGA_B <= {COLOR_DEPTH{color[0]}};
    end else begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end
  end

  assign VGA_HS      = dly.hs;
  assign VGA_VS      = dly.vs;
  assign VGA_BLANK_N = dly.vis;
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: SYNC_DELAY=1 instance with constant color, SYNC_DELAY=3 instance fed by a 2-cycle image model.
module tb_vga_timing_generator;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  color1  = 3'b101;
  logic [2:0]  c1      = 3'b000;
  logic [2:0]  color3  = 3'b000;

  logic [11:0] x, y, x3, y3;
  logic        frame_tick, hs, vs, blank_n, sync_n;
  logic        ft3, hs3, vs3, blank3, sync3;
  logic [7:0]  r, g, b, r3, g3, b3;

  int n_cmp = 0;
  int n_bad = 0;

  // reference raster position and one-cycle history of the raw sync signals
  int   hb, vb, step_no, model_err, first_bad;
  logic p_hs, p_vs, p_vis;
  logic [11:0] exp_x, exp_y, hf, vf;
  logic        exp_hs, exp_vs, exp_blank, exp_ft;
  logic [7:0]  exp_r, exp_b;

  always #20 clk = ~clk;

  always @(posedge clk) begin
    c1     <= (x3 == 12'd1) ? 3'b001 : 3'b000;
    color3 <= c1;
  end

  vga_timing_generator #(.COLOR_DEPTH(8), .SYNC_DELAY(1)) dut1 (
    .CLOCK_25(clk), .reset_n(reset_n), .color(color1), .x(x), .y(y), .frame_tick(frame_tick),
    .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n),
    .VGA_R(r), .VGA_G(g), .VGA_B(b));

  vga_timing_generator #(.COLOR_DEPTH(8), .SYNC_DELAY(3)) dut3 (
    .CLOCK_25(clk), .reset_n(reset_n), .color(color3), .x(x3), .y(y3), .frame_tick(ft3),
    .VGA_HS(hs3), .VGA_VS(vs3), .VGA_BLANK_N(blank3), .VGA_SYNC_N(sync3),
    .VGA_R(r3), .VGA_G(g3), .VGA_B(b3));

  function automatic logic raw_hs(input int h);
    return !(h >= 656 && h <= 751);
  endfunction
  function automatic logic raw_vs(input int v);
    return !(v >= 490 && v <= 491);
  endfunction
  function automatic logic raw_vis(input int h, input int v);
    return (h < 640) && (v < 480);
  endfunction

  task automatic advance();
    hb++;
    if (hb == 800) begin
      hb = 0;
      vb++;
      if (vb == 525) vb = 0;
    end
  endtask

  task automatic model_reset();
    hb = 0; vb = 0; step_no = 0;
    p_hs = 1'b1; p_vs = 1'b1; p_vis = 1'b0;
  endtask

  // One pixel clock of the SYNC_DELAY=1 reference; every output is tallied into model_err.
  task automatic tick();
    @(negedge clk);
    step_no++;
    exp_x     = (hb < 640) ? 12'(hb + 1) : 12'd0;
    exp_y     = (vb < 480) ? 12'(vb + 1) : 12'd0;
    exp_hs    = p_hs;
    exp_vs    = p_vs;
    exp_blank = p_vis;
    exp_r     = p_vis ? 8'hFF : 8'h00;
    exp_b     = p_vis ? 8'hFF : 8'h00;
    exp_ft    = (hb == 0) && (vb == 480);
    if ({x, y, hs, vs, blank_n, r, g, b, frame_tick, sync_n} !==
        {exp_x, exp_y, exp_hs, exp_vs, exp_blank, exp_r, 8'h00, exp_b, exp_ft, 1'b0}) begin
      if (model_err == 0) first_bad = step_no;
      model_err++;
    end
    p_hs  = raw_hs(hb);
    p_vs  = raw_vs(vb);
    p_vis = raw_vis(hb, vb);
    advance();
  endtask

  // Teleport both instances' counters to (H,V); called at a falling edge.
  task automatic jump(input int H, input int V);
    hf = 12'(H);
    vf = 12'(V);
    force dut1.h_cnt = hf;
    force dut1.v_cnt = vf;
    force dut3.h_cnt = hf;
    force dut3.v_cnt = vf;
    #1;
    release dut1.h_cnt;
    release dut1.v_cnt;
    release dut3.h_cnt;
    release dut3.v_cnt;
    p_hs = raw_hs(H); p_vs = raw_vs(V); p_vis = raw_vis(H, V);
    hb = H; vb = V;
    advance();
    step_no = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (x !== 12'd0) begin n_bad++; $display("FAIL reset_x: got %0d want 0", x); end
    n_cmp++; if (y !== 12'd0) begin n_bad++; $display("FAIL reset_y: got %0d want 0", y); end
    n_cmp++; if (hs !== 1'b1) begin n_bad++; $display("FAIL reset_hs: got %b want 1", hs); end
    n_cmp++; if (vs !== 1'b1) begin n_bad++; $display("FAIL reset_vs: got %b want 1", vs); end
    n_cmp++; if (blank_n !== 1'b0) begin n_bad++; $display("FAIL reset_blank_n: got %b want 0", blank_n); end
    n_cmp++; if ({r, g, b} !== 24'h0) begin n_bad++; $display("FAIL reset_rgb: got %h want 0", {r, g, b}); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_frame_tick: got %b want 0", frame_tick); end
    n_cmp++; if (sync_n !== 1'b0) begin n_bad++; $display("FAIL sync_n: got %b want 0", sync_n); end
    n_cmp++; if ({hs3, vs3, blank3} !== 3'b110) begin n_bad++; $display("FAIL reset_sync_d3: got %b want 110", {hs3, vs3, blank3}); end
  endtask

  task automatic test_first_lines();
    int   hs_l0 = 0, hs_l1 = 0, first_hs = -1, second_fall = -1, blank_l0 = 0;
    int   first_hs3 = -1, first_blank3 = -1, blue_starts = 0, blue_err = 0;
    logic prev_hs = 1'b1, prev_b3 = 1'b0;
    reset_n = 1'b1;
    model_reset();
    model_err = 0;
    for (int k = 1; k <= 1700; k++) begin
      tick();
      if (k == 1) begin
        n_cmp++; if (x !== 12'd1) begin n_bad++; $display("FAIL first_x: got %0d want 1", x); end
        n_cmp++; if (y !== 12'd1) begin n_bad++; $display("FAIL first_y: got %0d want 1", y); end
      end
      if (k == 640) begin
        n_cmp++; if (x !== 12'd640) begin n_bad++; $display("FAIL last_visible_x: got %0d want 640", x); end
      end
      if (k == 641) begin
        n_cmp++; if (x !== 12'd0) begin n_bad++; $display("FAIL front_porch_x: got %0d want 0", x); end
      end
      if (k == 801) begin
        n_cmp++; if ({x, y} !== {12'd1, 12'd2}) begin n_bad++; $display("FAIL line1_xy: got %0d/%0d want 1/2", x, y); end
      end
      if (!hs) begin
        if (first_hs < 0) first_hs = k;
        if (k <= 800) hs_l0++;
        else if (k <= 1600) hs_l1++;
        if (prev_hs && k > 800 && second_fall < 0) second_fall = k;
      end
      prev_hs = hs;
      if (blank_n && k <= 800) blank_l0++;
      if (!hs3 && first_hs3 < 0) first_hs3 = k;
      if (blank3 && first_blank3 < 0) first_blank3 = k;
      if (blank3 && !prev_b3) begin
        blue_starts++;
        if ({r3, g3, b3} !== 24'h0000FF) blue_err++;
      end else if ({r3, g3, b3} !== 24'h0) begin
        blue_err++;
      end
      prev_b3 = blank3;
    end
    n_cmp++; if (model_err !== 0) begin n_bad++; $display("FAIL lines_model: %0d bad cycles, first at step %0d, want 0", model_err, first_bad); end
    n_cmp++; if (hs_l0 !== 96) begin n_bad++; $display("FAIL hs_width_line0: got %0d want 96", hs_l0); end
    n_cmp++; if (hs_l1 !== 96) begin n_bad++; $display("FAIL hs_width_line1: got %0d want 96", hs_l1); end
    n_cmp++; if (first_hs !== 658) begin n_bad++; $display("FAIL hs_first_fall: got %0d want 658", first_hs); end
    n_cmp++; if (second_fall !== 1458) begin n_bad++; $display("FAIL hs_period: got %0d want 1458", second_fall); end
    n_cmp++; if (blank_l0 !== 640) begin n_bad++; $display("FAIL blank_count_line0: got %0d want 640", blank_l0); end
    n_cmp++; if (first_hs3 !== 660) begin n_bad++; $display("FAIL hs_first_fall_d3: got %0d want 660", first_hs3); end
    n_cmp++; if (first_blank3 !== 4) begin n_bad++; $display("FAIL blank_first_d3: got %0d want 4", first_blank3); end
    n_cmp++; if (blue_starts !== 3) begin n_bad++; $display("FAIL line_starts_d3: got %0d want 3", blue_starts); end
    n_cmp++; if (blue_err !== 0) begin n_bad++; $display("FAIL blue_alignment_d3: got %0d bad cycles want 0", blue_err); end
  endtask

  task automatic test_vsync();
    int vs_cnt = 0, vs_first = -1, vs3_cnt = 0, vs3_first = -1;
    jump(790, 489);
    model_err = 0;
    for (int j = 1; j <= 2500; j++) begin
      tick();
      if (j == 10) begin
        n_cmp++; if ({x, y} !== {12'd1, 12'd0}) begin n_bad++; $display("FAIL blank_line_xy: got %0d/%0d want 1/0", x, y); end
      end
      if (!vs) begin vs_cnt++; if (vs_first < 0) vs_first = j; end
      if (!vs3) begin vs3_cnt++; if (vs3_first < 0) vs3_first = j; end
    end
    n_cmp++; if (model_err !== 0) begin n_bad++; $display("FAIL vsync_model: %0d bad cycles, first at step %0d, want 0", model_err, first_bad); end
    n_cmp++; if (vs_cnt !== 1600) begin n_bad++; $display("FAIL vs_width: got %0d want 1600", vs_cnt); end
    n_cmp++; if (vs_first !== 11) begin n_bad++; $display("FAIL vs_first_fall: got %0d want 11", vs_first); end
    n_cmp++; if (vs3_cnt !== 1600) begin n_bad++; $display("FAIL vs_width_d3: got %0d want 1600", vs3_cnt); end
    n_cmp++; if (vs3_first !== 13) begin n_bad++; $display("FAIL vs_first_fall_d3: got %0d want 13", vs3_first); end
  endtask

  task automatic test_frame_tick_wrap();
    int ft_cnt = 0, ft_at = -1, ft3_cnt = 0;
    jump(790, 479);
    model_err = 0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (frame_tick) begin ft_cnt++; ft_at = j; end
      if (ft3) ft3_cnt++;
    end
    n_cmp++; if (ft_cnt !== 1) begin n_bad++; $display("FAIL frame_tick_count: got %0d want 1", ft_cnt); end
    n_cmp++; if (ft_at !== 10) begin n_bad++; $display("FAIL frame_tick_position: got step %0d want 10", ft_at); end
    n_cmp++; if (ft3_cnt !== 1) begin n_bad++; $display("FAIL frame_tick_count_d3: got %0d want 1", ft3_cnt); end
    jump(790, 524);
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (j == 10) begin
        n_cmp++; if ({x, y} !== {12'd1, 12'd1}) begin n_bad++; $display("FAIL wrap_xy: got %0d/%0d want 1/1", x, y); end
      end
    end
    n_cmp++; if (model_err !== 0) begin n_bad++; $display("FAIL tick_wrap_model: %0d bad cycles, first at step %0d, want 0", model_err, first_bad); end
  endtask

  task automatic test_mid_reset();
    int first_hs = -1;
    jump(290, 200);
    repeat (10) tick();
    #5 reset_n = 1'b0;
    #1;
    n_cmp++; if ({x, y} !== 24'h0) begin n_bad++; $display("FAIL midreset_xy: got %0d/%0d want 0/0", x, y); end
    n_cmp++; if ({hs, vs, blank_n} !== 3'b110) begin n_bad++; $display("FAIL midreset_sync: got %b want 110", {hs, vs, blank_n}); end
    n_cmp++; if ({r, g, b} !== 24'h0) begin n_bad++; $display("FAIL midreset_rgb: got %h want 0", {r, g, b}); end
    n_cmp++; if ({hs3, vs3, blank3, r3, g3, b3} !== {3'b110, 24'h0}) begin n_bad++; $display("FAIL midreset_d3: got %b/%h", {hs3, vs3, blank3}, {r3, g3, b3}); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    model_err = 0;
    for (int k = 1; k <= 800; k++) begin
      tick();
      if (k == 1) begin
        n_cmp++; if ({x, y} !== {12'd1, 12'd1}) begin n_bad++; $display("FAIL post_reset_xy: got %0d/%0d want 1/1", x, y); end
      end
      if (!hs && first_hs < 0) first_hs = k;
    end
    n_cmp++; if (first_hs !== 658) begin n_bad++; $display("FAIL post_reset_hs_fall: got %0d want 658", first_hs); end
    n_cmp++; if (model_err !== 0) begin n_bad++; $display("FAIL post_reset_model: %0d bad cycles, first at step %0d, want 0", model_err, first_bad); end
    // reset landing inside a sync pulse must release HS at once
    jump(700, 10);
    repeat (3) tick();
    n_cmp++; if (hs !== 1'b0) begin n_bad++; $display("FAIL hs_low_before_reset: got %b want 0", hs); end
    #5 reset_n = 1'b0;
    #1;
    n_cmp++; if ({hs, hs3} !== 2'b11) begin n_bad++; $display("FAIL hs_abort_on_reset: got %b want 11", {hs, hs3}); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_first_lines();
    test_vsync();
    test_frame_tick_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
